synchronizer: RTL and testbench

SYNCHRONIZER -- requirements
Module: synchronizer

---
 rtl/synchronizer.sv | 57 +++++
 tb/tb_synchronizer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - multi-stage flop synchronizer for asynchronous inputs
//
// Purpose: brings WIDTH independent asynchronous bits into the clock domain
// through a chain of STAGES flops per bit. Bits are not related to one another.
// A multi-bit bus passed through here is only coherent if at most one bit changes
// at a time, or if the source holds the bus stable long enough.
//
// Parameters:
//   STAGES   flops per chain, 1..8 (2 is the usual metastability budget)
//   WIDTH    number of independent bits, >= 1
//
// Ports:
//   clock    destination-domain clock, all flops capture on the rising edge
//   resetn   asynchronous active-low reset, clears every stage
//   data_in  asynchronous input bits
//   data_out synchronized bits, taken straight from the last stage flop

module synchronizer #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $fatal(1, "synchronizer: STAGES=%0d outside legal range 1..8", STAGES);
  end

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "synchronizer: WIDTH=%0d must be at least 1", WIDTH);
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    // The attribute keeps the chain flops adjacent and out of retiming.
    // It also identifies sync_ff[0] as the CDC capture flop.
    (* async_reg = "true" *) logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        sync_ff <= '0;
      end else begin
        sync_ff[0] <= data_in[b];
        // With STAGES=1 this loop is empty, and the block becomes one register.
        for (int s = 1; s < STAGES; s++) begin
          sync_ff[s] <= sync_ff[s-1];
        end
      end
    end

    // No logic follows the last stage. A glitch here would defeat the chain.
    assign data_out[b] = sync_ff[STAGES-1];
  end

endmodule

// File: tb/tb_synchronizer.sv
// tb/tb_synchronizer.sv - scoreboard bench for synchronizer latency and reset behaviour

module tb_synchronizer;

  logic       clock;
  logic       resetn;
  logic       bit_in;
  logic [3:0] wide_in;
  logic       o1, o2, o3, o4, o5;
  logic [3:0] wide_out;
  logic [4:0] narrow;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [4:0] narrow;
    logic [3:0] wide;
  } exp_t;

  exp_t exp_q[$];

  assign narrow = {o5, o4, o3, o2, o1};

  synchronizer #(.STAGES(1), .WIDTH(1)) u_s1 (.clock(clock), .resetn(resetn), .data_in(bit_in), .data_out(o1));
  synchronizer #(.STAGES(2), .WIDTH(1)) u_s2 (.clock(clock), .resetn(resetn), .data_in(bit_in), .data_out(o2));
  synchronizer #(.STAGES(3), .WIDTH(1)) u_s3 (.clock(clock), .resetn(resetn), .data_in(bit_in), .data_out(o3));
  synchronizer #(.STAGES(4), .WIDTH(1)) u_s4 (.clock(clock), .resetn(resetn), .data_in(bit_in), .data_out(o4));
  synchronizer #(.STAGES(5), .WIDTH(1)) u_s5 (.clock(clock), .resetn(resetn), .data_in(bit_in), .data_out(o5));
  synchronizer #(.STAGES(3), .WIDTH(4)) u_w3 (.clock(clock), .resetn(resetn), .data_in(wide_in), .data_out(wide_out));

  // period 20, rising edges at 10, 30, 50, ...
  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // The stimulus has just changed. gap is the time left until the next rising edge.
  // Entry k is what the outputs must show after k edges. A chain of S stages reaches
  // the new value once k >= S. Entry 0 is sampled just before the first edge.
  // Entries 1..7 are sampled 1 time unit after each edge. The last entries must hold.
  task automatic expect_seq(input string label, input logic old_v, input logic new_v,
                            input logic [3:0] wold, input logic [3:0] wnew, input int gap);
    exp_t e;
    for (int k = 0; k <= 7; k++) begin
      for (int s = 1; s <= 5; s++) e.narrow[s-1] = (k >= s) ? new_v : old_v;
      e.wide = (k >= 3) ? wnew : wold;
      exp_q.push_back(e);
    end
    for (int k = 0; k <= 7; k++) begin
      if (k == 0) #(gap - 1);
      else begin
        @(posedge clock);
        #1;
      end
      e = exp_q.pop_front();
      check_eq($sformatf("%s k=%0d narrow", label, k), {3'b000, narrow}, {3'b000, e.narrow});
      check_eq($sformatf("%s k=%0d wide", label, k), {4'h0, wide_out}, {4'h0, e.wide});
    end
  endtask

  initial begin
    resetn  = 1'b1;
    bit_in  = 1'b0;
    wide_in = 4'h0;
    #1 resetn = 1'b0;
    #2;
    check_eq("reset_state narrow", {3'b000, narrow}, 8'h00);
    check_eq("reset_state wide", {4'h0, wide_out}, 8'h00);
    #9 resetn = 1'b1;

    // A change at 25% of the period is followed by the next edge 15 later.
    @(posedge clock); #5;
    bit_in = 1'b1; wide_in = 4'b1010;
    expect_seq("rise25", 1'b0, 1'b1, 4'h0, 4'b1010, 15);

    @(posedge clock); #5;
    bit_in = 1'b0; wide_in = 4'h0;
    expect_seq("fall25", 1'b1, 1'b0, 4'b1010, 4'h0, 15);

    // A change at 75% of the period is followed by the next edge 5 later.
    @(posedge clock); #15;
    bit_in = 1'b1; wide_in = 4'b1010;
    expect_seq("rise75", 1'b0, 1'b1, 4'h0, 4'b1010, 5);

    @(posedge clock); #15;
    bit_in = 1'b0; wide_in = 4'h0;
    expect_seq("fall75", 1'b1, 1'b0, 4'b1010, 4'h0, 5);

    // Fill the chains partly, then assert reset between edges.
    @(posedge clock); #5;
    bit_in = 1'b1; wide_in = 4'b1010;
    @(posedge clock);
    @(posedge clock); #1;
    check_eq("partial narrow", {3'b000, narrow}, 8'b0000_0011);
    check_eq("partial wide", {4'h0, wide_out}, 8'h00);
    #4 resetn = 1'b0;
    #1;
    check_eq("async_reset narrow", {3'b000, narrow}, 8'h00);
    check_eq("async_reset wide", {4'h0, wide_out}, 8'h00);
    @(posedge clock); #1;
    check_eq("held_reset narrow", {3'b000, narrow}, 8'h00);
    check_eq("held_reset wide", {4'h0, wide_out}, 8'h00);
    #4 resetn = 1'b1;
    expect_seq("post_reset", 1'b0, 1'b1, 4'h0, 4'b1010, 15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
